// File: rtl/cabac_byte_feeder.sv
// cabac_byte_feeder: unpacks 32-bit big-endian stream words into a byte FIFO
// and hands the head byte to the CABAC bin decoders one byte per consuming step.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   flush               sync clear of FIFO, counter and underflow (slice start)
//   word_in/word_bytes  stream word, 1..4 valid bytes MSB-aligned
//   word_valid/ready    word handshake; ready depends on registered occupancy only
//   read_byte           head byte (00 when empty), byte_avail = FIFO non-empty
//   request_byte        decoder step needs a byte
//   bin_step            decoder commits a step this cycle
//   consumed_cnt        bytes popped since reset/flush
//   underflow           sticky, set when a pop is requested on an empty FIFO

module cabac_byte_feeder #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [31:0]      word_in,
    input  logic [2:0]       word_bytes,
    input  logic             word_valid,
    output logic             word_ready,
    output logic [7:0]       read_byte,
    output logic             byte_avail,
    input  logic             request_byte,
    input  logic             bin_step,
    output logic [CNT_W-1:0] consumed_cnt,
    output logic             underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [OW-1:0] occ;

    logic          push;
    logic          pop_req;
    logic          pop;
    logic [2:0]    n_bytes;
    logic [OW-1:0] occ_nxt;

    // Four free slots are needed before a whole word can be accepted.
    assign word_ready = (occ <= OW'(DEPTH - 4));
    assign byte_avail = (occ != '0);
    assign read_byte  = byte_avail ? mem[rd_ptr] : 8'h00;

    assign push    = word_valid & word_ready;
    assign pop_req = bin_step & request_byte;
    assign pop     = pop_req & byte_avail;
    assign n_bytes = (word_bytes > 3'd4) ? 3'd4 : word_bytes;

    always_comb begin
        occ_nxt = occ;
        if (push)
            occ_nxt = occ_nxt + OW'(n_bytes);
        if (pop)
            occ_nxt = occ_nxt - OW'(1);
    end

    // Byte storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            for (int i = 0; i < 4; i++) begin
                if (3'(i) < n_bytes)
                    mem[wr_ptr + AW'(i)] <= word_in[31 - 8*i -: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            occ          <= '0;
            consumed_cnt <= '0;
            underflow    <= 1'b0;
        end else if (flush) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            occ          <= '0;
            consumed_cnt <= '0;
            underflow    <= 1'b0;
        end else begin
            occ <= occ_nxt;
            if (push)
                wr_ptr <= wr_ptr + AW'(n_bytes);
            if (pop) begin
                rd_ptr       <= rd_ptr + AW'(1);
                consumed_cnt <= consumed_cnt + CNT_W'(1);
            end
            if (pop_req && !byte_avail)
                underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cabac_byte_feeder.sv
// tb_cabac_byte_feeder: scoreboard bench for cabac_byte_feeder.
// Expected bytes are queued on push and compared when popped.

module tb_cabac_byte_feeder;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [31:0] word_in;
    logic [2:0]  word_bytes;
    logic        word_valid;
    logic        word_ready;
    logic [7:0]  read_byte;
    logic        byte_avail;
    logic        request_byte;
    logic        bin_step;
    logic [31:0] consumed_cnt;
    logic        underflow;

    int total = 0;
    int bad   = 0;

    logic [7:0]  sb_q[$];
    logic [31:0] m_cnt = 0;
    logic        m_uf  = 0;

    cabac_byte_feeder #(.DEPTH(DEPTH), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .word_in(word_in), .word_bytes(word_bytes),
        .word_valid(word_valid), .word_ready(word_ready),
        .read_byte(read_byte), .byte_avail(byte_avail),
        .request_byte(request_byte), .bin_step(bin_step),
        .consumed_cnt(consumed_cnt), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_state();
        chk("occ",   32'(dut.occ), 32'(sb_q.size()));
        chk("ready", 32'(word_ready), 32'(sb_q.size() <= DEPTH - 4));
        chk("avail", 32'(byte_avail), 32'(sb_q.size() != 0));
        chk("rbyte", 32'(read_byte), 32'(sb_q.size() != 0 ? sb_q[0] : 8'h00));
        chk("cnt",   consumed_cnt, m_cnt);
        chk("uf",    32'(underflow), 32'(m_uf));
    endtask

    // One clock: check state, drive inputs at negedge, update model.
    task automatic step(input logic wv, input logic [31:0] w,
                        input logic [2:0] nb, input logic bs,
                        input logic rq, input logic fl);
        logic rdy;
        int   n;
        @(negedge clk);
        check_state();
        word_valid   = wv;
        word_in      = w;
        word_bytes   = nb;
        bin_step     = bs;
        request_byte = rq;
        flush        = fl;
        #1;
        rdy = (sb_q.size() <= DEPTH - 4);
        if (bs && rq) begin
            if (sb_q.size() != 0) begin
                chk("pop", 32'(read_byte), 32'(sb_q.pop_front()));
                m_cnt++;
            end else begin
                m_uf = 1'b1;
            end
        end
        if (wv && rdy) begin
            n = (nb > 4) ? 4 : int'(nb);
            for (int i = 0; i < n; i++)
                sb_q.push_back(w[31 - 8*i -: 8]);
        end
        if (fl) begin
            sb_q.delete();
            m_cnt = 0;
            m_uf  = 1'b0;
        end
    endtask

    task automatic idle();
        step(0, 32'h0, 3'd0, 0, 0, 0);
    endtask

    task automatic pop1();
        step(0, 32'h0, 3'd0, 1, 1, 0);
    endtask

    initial begin
        rst_n        = 1'b0;
        flush        = 1'b0;
        word_in      = '0;
        word_bytes   = '0;
        word_valid   = 1'b0;
        request_byte = 1'b0;
        bin_step     = 1'b0;
        #12;
        chk("rst_ready", 32'(word_ready), 32'd1);
        chk("rst_avail", 32'(byte_avail), 32'd0);
        chk("rst_rbyte", 32'(read_byte), 32'd0);
        chk("rst_cnt",   consumed_cnt, 32'd0);
        chk("rst_uf",    32'(underflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // basic word, non-consuming steps, then four pops
        step(1, 32'hA1B2C3D4, 3'd4, 0, 0, 0);
        step(0, 32'h0, 3'd0, 1, 0, 0);
        step(0, 32'h0, 3'd0, 0, 1, 0);
        repeat (4) pop1();
        idle();
        chk("cnt4", consumed_cnt, 32'd4);

        // fill to DEPTH and drain partially
        step(1, 32'h01020304, 3'd4, 0, 0, 0);
        step(1, 32'h05060708, 3'd4, 0, 0, 0);
        step(1, 32'hDEADBEEF, 3'd4, 0, 0, 0);
        pop1();
        repeat (4) pop1();
        idle();
        chk("occ3", 32'(dut.occ), 32'd3);

        // concurrent push and pop with head 11
        step(0, 32'h0, 3'd0, 0, 0, 1);
        step(1, 32'h11223344, 3'd4, 0, 0, 0);
        step(1, 32'hAABBCCDD, 3'd4, 1, 1, 0);
        idle();
        chk("occ7", 32'(dut.occ), 32'd7);

        // random traffic across many pointer wraps
        for (int k = 0; k < 120; k++)
            step(1'($urandom_range(0, 1)), $urandom, 3'($urandom_range(0, 5)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        while (sb_q.size() != 0) pop1();
        idle();

        // partial word, zero-byte word, clamp, underflow
        step(0, 32'h0, 3'd0, 0, 0, 1);
        step(1, 32'hEEFF0000, 3'd2, 0, 0, 0);
        step(1, 32'h99999999, 3'd0, 0, 0, 0);
        idle();
        chk("occ2", 32'(dut.occ), 32'd2);
        pop1();
        pop1();
        pop1();
        idle();
        chk("uf_set", 32'(underflow), 32'd1);
        chk("uf_cnt", consumed_cnt, 32'd2);
        step(1, 32'h31323334, 3'd7, 0, 0, 0);
        repeat (4) pop1();

        // flush with concurrent push and pop at occ 5, underflow set
        step(1, 32'h41424344, 3'd4, 0, 0, 0);
        step(1, 32'h50000000, 3'd1, 0, 0, 0);
        idle();
        chk("occ5", 32'(dut.occ), 32'd5);
        step(1, 32'h61626364, 3'd4, 1, 1, 1);
        idle();
        chk("fl_occ", 32'(dut.occ), 32'd0);
        chk("fl_uf",  32'(underflow), 32'd0);

        // async reset mid-operation
        step(1, 32'h71727374, 3'd4, 0, 0, 0);
        pop1();
        @(negedge clk);
        word_valid = 1'b0;
        bin_step   = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_avail", 32'(byte_avail), 32'd0);
        chk("arst_cnt",   consumed_cnt, 32'd0);
        chk("arst_ready", 32'(word_ready), 32'd1);
        sb_q.delete();
        m_cnt = 0;
        m_uf  = 1'b0;
        #2;
        rst_n = 1'b1;
        step(1, 32'h81828384, 3'd4, 0, 0, 0);
        repeat (4) pop1();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
